serial_feeder: RTL
==================

SERIAL_FEEDER -- requirements
Module: serial_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = serialise MSB first, 0 = LSB first.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port din  input  WIDTH  the parallel word to serialise.
REQ-006 The block SHALL have port din_valid  input  1  din holds a word to accept.
REQ-007 The block SHALL have port din_ready  output  1  the block can accept a word this cycle.
REQ-008 The block SHALL have port abort  input  1  synchronous request to abandon the current word.
REQ-009 The block SHALL have port X  output  1  registered serial bit; feeds the sequence detector's X input.
REQ-010 The block SHALL have port x_valid  output  1  X carries a payload or parity bit this cycle.
REQ-011 The block SHALL have port busy  output  1  the block is in a non-IDLE state.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse after a word completes without abort.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, PARITY (present only when the Configuration macro is defined) and DONE.
REQ-014 In IDLE: din_ready=1, X=0, x_valid=0, busy=0; a handshake (din_valid & din_ready at a rising edge) SHALL capture din into the shift register, clear the bit counter and enter SHIFT.
REQ-015 In SHIFT the block SHALL drive one bit per cycle on X with x_valid=1, starting in the cycle immediately after the handshake edge (latency 1), in the order set by MSB_FIRST.
REQ-016 The bit counter SHALL be $clog2(WIDTH+1) bits wide; after the bit with index count==WIDTH-1, the FSM SHALL enter PARITY if compiled in, otherwise DONE.
REQ-017 In DONE: X=0, x_valid=0, done=1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-018 din_ready SHALL be 0 in every state other than IDLE; din and din_valid SHALL be ignored outside IDLE.
REQ-019 If abort=1 in SHIFT or PARITY, the FSM SHALL go directly to IDLE at the next edge with X=0 and x_valid=0, and done SHALL not pulse.
REQ-020 If abort=1 and din_valid=1 together in IDLE, abort SHALL win: no capture, and the FSM stays in IDLE.
REQ-021 Word period SHALL be WIDTH+2 cycles from handshake to the next din_ready (WIDTH+3 with parity).
REQ-022 X SHALL be 0 whenever x_valid=0, so the downstream detector returns to its idle state between words.

Reset
REQ-023 RESET_N=0 SHALL immediately force state IDLE, shift register 0, counter 0, X=0, x_valid=0, busy=0, done=0, din_ready=1.
REQ-024 Reset asserted mid-word SHALL discard the word; no done pulse SHALL follow its release.

Configuration
REQ-025 Macro SERIAL_FEEDER_PARITY_EN, when defined, SHALL add state PARITY: one cycle with X = XOR of all captured din bits (even parity) and x_valid=1, placed between the last payload bit and DONE.
REQ-026 Without SERIAL_FEEDER_PARITY_EN, the PARITY state and the parity logic SHALL be absent, and SHIFT SHALL go directly to DONE.

Structure
REQ-027 A shared package serial_feeder_pkg SHALL hold the state-encoding typedef (2-bit) and the state constants ST_IDLE, ST_SHIFT, ST_PARITY and ST_DONE.
REQ-028 A sub-module piso_shreg (parallel load, shift enable, direction from MSB_FIRST, serial out) SHALL implement the datapath; the FSM SHALL stay in serial_feeder.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, din=8'hB3 handshake -> X=1,0,1,1,0,0,1,1 on cycles 1-8 with x_valid=1; done=1 on cycle 9; din_ready=1 on cycle 10.
REQ-030 MSB_FIRST=0, din=8'h01 -> X=1 then seven 0s; connected detector sees no run of two 1s, and its Z stays 0.
REQ-031 SERIAL_FEEDER_PARITY_EN defined, din=8'h07 -> 8 payload bits, then X=1 (parity) on cycle 9; done on cycle 10.
REQ-032 din_valid held high continuously with 8'hFF, 8'h00 -> second word is captured only in IDLE; X sequence is 8 ones, 2 zero cycles, 8 zeros.
REQ-033 abort=1 during the 4th bit of 8'hFF -> X=0 and x_valid=0 next cycle, no done, din_ready=1 the cycle after the abort edge.
REQ-034 RESET_N pulsed low during the 5th bit -> all outputs take their reset values at once; no done pulse after release.

Source files
------------

// File: rtl/serial_feeder_pkg.sv
// serial_feeder_pkg: shared definitions for the serial feeder.
//   state_t - 2-bit FSM state encoding (ST_IDLE, ST_SHIFT, ST_PARITY, ST_DONE).
package serial_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: parallel-in serial-out shift register used as the feeder datapath.
//   clk       - clock, rising edge
//   RESET_N   - asynchronous active-low reset, clears the register
//   load      - load load_data into the register (has priority over shift_en)
//   load_data - parallel word
//   shift_en  - advance the register by one bit
//   sout      - current serial bit (MSB or LSB of the register, per MSB_FIRST)
module piso_shreg #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sout
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift_en) begin
      if (MSB_FIRST != 0) begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sout = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/serial_feeder.sv
// serial_feeder: accepts a parallel word over a valid/ready handshake and plays it out one bit
// per cycle on X, framed by x_valid, followed by a one-cycle done pulse.
// Optional even-parity bit after the payload when SERIAL_FEEDER_PARITY_EN is defined.
//   clk       - clock, rising edge
//   RESET_N   - asynchronous active-low reset
//   din       - parallel word, din_valid - word offered, din_ready - word can be taken (IDLE)
//   abort     - abandon the current word, return to IDLE without done
//   X         - serial bit (0 whenever x_valid is 0), x_valid - X carries payload/parity
//   busy      - FSM not in IDLE, done - one-cycle pulse after a completed word
module serial_feeder
  import serial_feeder_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             abort,
  output logic             X,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

`ifdef SERIAL_FEEDER_PARITY_EN
  localparam state_t AfterShift = ST_PARITY;
`else
  localparam state_t AfterShift = ST_DONE;
`endif

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load, shift_en, sout;

  piso_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_piso (
    .clk      (clk),
    .RESET_N  (RESET_N),
    .load     (load),
    .load_data(din),
    .shift_en (shift_en),
    .sout     (sout)
  );

`ifdef SERIAL_FEEDER_PARITY_EN
  // Parity is taken from the captured word, so later din changes cannot disturb it.
  logic parity_q;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^din;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    X         = 1'b0;
    x_valid   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    din_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        din_ready = 1'b1;
        busy      = 1'b0;
        // abort outranks a simultaneous offer
        if (din_valid && !abort) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        X       = sout;
        x_valid = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LastIdx) begin
          state_d = AfterShift;
        end else begin
          cnt_d    = cnt_q + CntW'(1);
          shift_en = 1'b1;
        end
      end
`ifdef SERIAL_FEEDER_PARITY_EN
      ST_PARITY: begin
        X       = parity_q;
        x_valid = 1'b1;
        state_d = abort ? ST_IDLE : ST_DONE;
      end
`endif
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
